alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Parametrised multi-cycle control unit for the Mini-SRC datapath.
- Generates the full per-state control word for register-register and unary ALU instructions: fetch, decode, execute and writeback, in place of hand-coded bench state machines.
- Adds a start/done handshake, a memory-ready stall during fetch, and a two-result writeback path for MUL/DIV into HI/LO.
- Sits between a top-level run controller (or bench) and the datapath.

Parameters:
NUM_REGS, 16, number of general registers; width of the one-hot r_in/r_out vectors.
REG_SEL_W, 4, width of the Ra/Rb/Rc fields.
OPC_FIRST, 5'd2, lowest legal ALU opcode.
OPC_LAST, 5'd19, highest legal ALU opcode.
ALU_OFFSET, 5'd2, subtracted from the opcode to form alu_control (opcode 2 gives ALU_Control 0, ADD).
OPC_MUL, 5'd16, multiply opcode (two-result writeback).
OPC_DIV, 5'd17, divide opcode (two-result writeback).
OPC_NEG, 5'd18, negate opcode (unary).
OPC_NOT, 5'd19, not opcode (unary).

Ports:
clock  in  1  system clock; all state changes on the rising edge.
clear  in  1  reset, asynchronous, active-low.
start  in  1  begin one instruction; sampled in IDLE only.
mem_rdy  in  1  memory has read data valid (fetch stall).
ir  in  32  IR register contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
busy  out  1  high from T0 through the last execute state.
done  out  1  one-cycle pulse on instruction completion.
err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
r_in  out  NUM_REGS  one-hot register load enables.
r_out  out  NUM_REGS  one-hot register bus drives.
pc_out, mar_in, inc_pc, z_in, zlow_out, zhigh_out, pc_in, read, mdr_in, mdr_out, ir_in, y_in, hi_in, lo_in  out  1 each  datapath controls.
alu_control  out  5  ALU operation select.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Reset (clear=0, any state, immediate): state goes to IDLE and every output is 0. No partial writeback completes.
- Controls are a Moore decode of the registered state and ir. Every control defaults to 0 in each state.
- IDLE: start=1 moves to T0 on the next edge. start is ignored in all other states.
- T0: pc_out, mar_in, inc_pc, z_in. Then T1.
- T1: zlow_out, pc_in, read, mdr_in.
  - pc_in is asserted only on the first T1 cycle.
  - The state holds while mem_rdy=0; read and mdr_in stay high throughout.
  - Moves to T2 on the edge where mem_rdy=1.
- T2: mdr_out, ir_in. Then T3.
- Decode in T3 and later uses ir as latched at the end of T2.
- Illegal opcode (outside [OPC_FIRST, OPC_LAST]): T3 asserts no controls, pulses done and err, and returns to IDLE.
- Binary op:
  - T3: r_out[Rb], y_in.
  - T4: r_out[Rc], alu_control = opcode - ALU_OFFSET (mod 32), z_in.
  - T5: zlow_out, r_in[Ra], done. Then IDLE.
- Unary op (NEG/NOT):
  - T3: r_out[Rb], alu_control, z_in.
  - T4: zlow_out, r_in[Ra], done. Then IDLE. T5 is not visited.
- MUL/DIV:
  - T3: r_out[Ra], y_in.
  - T4: r_out[Rb], alu_control, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in, done. Then IDLE.
- busy: 1 in T0 through the final state inclusive; 0 in IDLE.
- One-hot rules:
  - r_in and r_out each have at most one bit set.
  - A field value >= NUM_REGS leaves the vector all-zero. This is not an error.
- Exactly one bus driver per state (pc_out, zlow_out, zhigh_out, mdr_out or r_out); never two.
- start held high: one instruction per IDLE visit, with one IDLE cycle between instructions.

Optional Feature:
- Macro: ALU_SEQ_SINGLE_STEP_EN.
- With the macro defined:
  - Adds input step (1 bit).
  - Each non-IDLE state advance additionally requires step=1 at the edge. The T1 condition is mem_rdy & step.
  - Controls stay asserted while a state is held waiting for step.
  - The IDLE to T0 transition requires only start.
- Without the macro: no step port, and states advance as above.

Test Plan:
- ADD, R5=0x34, R6=0x45, ir=0x112B0000, mem_rdy=1 -> T0..T5 in 6 cycles; alu_control=0 in T4; r_in=16'h0004 in T5; R2=0x79; done pulses once.
- Same ADD with mem_rdy low for 3 cycles in T1 -> T1 lasts 4 cycles, pc_in high only on its first cycle, done 3 cycles later than before, R2=0x79.
- MUL (opcode 16, Ra=3, Rb=4), R3=0x10000, R4=0x10000 -> lo_in in T5, hi_in in T6; LO=0, HI=1; done in T6.
- NEG (opcode 18, Ra=1, Rb=7), R7=1 -> done at T4, T5 never entered, R1=0xFFFFFFFF.
- Opcode 5'd31 -> done and err pulse together in T3; no r_in asserted; back in IDLE the next cycle.
- clear driven low mid-T4 of an ADD -> all outputs 0 immediately, state IDLE, R2 unchanged; the next start runs normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit for Mini-SRC ALU instructions.
// Build option ALU_SEQ_SINGLE_STEP_EN adds a step input that gates every non-IDLE advance.
module alu_op_sequencer #(
  parameter int             NUM_REGS   = 16,
  parameter int             REG_SEL_W  = 4,
  parameter logic [4:0]     OPC_FIRST  = 5'd2,
  parameter logic [4:0]     OPC_LAST   = 5'd19,
  parameter logic [4:0]     ALU_OFFSET = 5'd2,
  parameter logic [4:0]     OPC_MUL    = 5'd16,
  parameter logic [4:0]     OPC_DIV    = 5'd17,
  parameter logic [4:0]     OPC_NEG    = 5'd18,
  parameter logic [4:0]     OPC_NOT    = 5'd19
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic                mem_rdy,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic                step,
`endif
  input  logic [31:0]         ir,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                z_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                hi_in,
  output logic                lo_in,
  output logic [4:0]          alu_control
);

  // state | meaning
  // IDLE  | waiting for start
  // T0    | PC to MAR, Z <= PC + 1
  // T1    | PC <= Z, memory read into MDR (holds until mem_rdy)
  // T2    | MDR to IR
  // T3    | first operand (or illegal-opcode exit)
  // T4    | ALU operation, or unary writeback
  // T5    | binary writeback, or LO writeback for MUL/DIV
  // T6    | HI writeback for MUL/DIV
  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t state, state_nxt;
  logic   t1_held;
  logic   adv;

`ifdef ALU_SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  logic [4:0]           opc;
  logic [REG_SEL_W-1:0] ra, rb, rc;
  logic                 legal, unary, muldiv;
  logic [4:0]           alu_op;

  assign opc    = ir[31:27];
  assign ra     = ir[26 -: REG_SEL_W];
  assign rb     = ir[22 -: REG_SEL_W];
  assign rc     = ir[18 -: REG_SEL_W];
  assign legal  = (opc >= OPC_FIRST) && (opc <= OPC_LAST);
  assign unary  = (opc == OPC_NEG) || (opc == OPC_NOT);
  assign muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
  assign alu_op = opc - ALU_OFFSET;

  // Field values beyond the register file decode to no register at all.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(sel) == i) onehot[i] = 1'b1;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)           state_nxt = S_T0;
      S_T0:   if (adv)             state_nxt = S_T1;
      S_T1:   if (mem_rdy && adv)  state_nxt = S_T2;
      S_T2:   if (adv)             state_nxt = S_T3;
      S_T3:   if (adv)             state_nxt = legal  ? S_T4 : S_IDLE;
      S_T4:   if (adv)             state_nxt = unary  ? S_IDLE : S_T5;
      S_T5:   if (adv)             state_nxt = muldiv ? S_T6 : S_IDLE;
      S_T6:   if (adv)             state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // t1_held marks the repeat cycles of a stalled fetch so pc_in fires only once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      t1_held <= 1'b0;
    end else begin
      state   <= state_nxt;
      t1_held <= (state == S_T1) && (state_nxt == S_T1);
    end
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    r_in        = '0;
    r_out       = '0;
    pc_out      = 1'b0;
    mar_in      = 1'b0;
    inc_pc      = 1'b0;
    z_in        = 1'b0;
    zlow_out    = 1'b0;
    zhigh_out   = 1'b0;
    pc_in       = 1'b0;
    read        = 1'b0;
    mdr_in      = 1'b0;
    mdr_out     = 1'b0;
    ir_in       = 1'b0;
    y_in        = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    alu_control = 5'd0;
    case (state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = !t1_held;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (!legal) begin
          done = 1'b1;
          err  = 1'b1;
        end else if (muldiv) begin
          r_out = onehot(ra);
          y_in  = 1'b1;
        end else if (unary) begin
          r_out       = onehot(rb);
          alu_control = alu_op;
          z_in        = 1'b1;
        end else begin
          r_out = onehot(rb);
          y_in  = 1'b1;
        end
      end
      S_T4: begin
        if (unary) begin
          zlow_out = 1'b1;
          r_in     = onehot(ra);
          done     = 1'b1;
        end else begin
          r_out       = muldiv ? onehot(rb) : onehot(rc);
          alu_control = alu_op;
          z_in        = 1'b1;
        end
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (muldiv) begin
          lo_in = 1'b1;
        end else begin
          r_in = onehot(ra);
          done = 1'b1;
        end
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
